uart_rx_param: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 23 ++
 rtl/uart_rx_param.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states, baud divider helpers.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_e;

  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

  // Width of a counter that runs 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud divider: tick_o pulses for one clock every DIV clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 651
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop sync, 3-sample majority vote, parity/framing/overrun
// flags, and a held output word released through a valid/ready handshake.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_fpga,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = cnt_width(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_LO   = SW'(M - 1);
  localparam logic [SW-1:0] S_MID  = SW'(M);
  localparam logic [SW-1:0] S_HI   = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    B_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    B_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_INV = (PARITY == PAR_ODD);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync2_q, rxd_s, tick;
  logic [SW-1:0]        samp_q, samp_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic                 vote_q, vote_d, vote_now;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, frame_now, commit;
  logic                 valid_q, valid_d, perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk_fpga),
    .rst_i  (reset),
    .tick_o (tick)
  );

  assign rxd_s     = sync2_q;
  assign vote_now  = maj3(smp_q[0], smp_q[1], rxd_s);
  assign frame_now = ferr_q | ~vote_now;

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= ST_IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      smp_q      <= '0;
      vote_q     <= 1'b0;
      sh_q       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      smp_q      <= smp_d;
      vote_q     <= vote_d;
      sh_q       <= sh_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    smp_d      = smp_q;
    vote_d     = vote_q;
    sh_d       = sh_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;

    if (tick) begin
      if (samp_q == S_LO)  smp_d[0] = rxd_s;
      if (samp_q == S_MID) smp_d[1] = rxd_s;
      if (samp_q == S_HI)  vote_d   = vote_now;
      samp_d = (samp_q == S_LAST) ? '0 : samp_q + 1'b1;

      unique case (state_q)
        ST_IDLE: if (!rxd_s) begin
          state_d = ST_START;
          samp_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
        ST_START: if (samp_q == S_LAST) begin
          state_d = vote_q ? ST_IDLE : ST_DATA;
          bit_d   = '0;
        end
        ST_DATA: if (samp_q == S_LAST) begin
          sh_d = {vote_q, sh_q[DATA_BITS-1:1]};
          if (bit_q == B_DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        ST_PARITY: if (samp_q == S_LAST) begin
          perr_d  = vote_q != ((^sh_q) ^ PAR_INV);
          bit_d   = '0;
          state_d = ST_STOP;
        end
        // The final stop bit commits early, at its last vote sample.
        ST_STOP: if (bit_q == B_STOP_LAST) begin
          if (samp_q == S_HI) begin
            ferr_d  = frame_now;
            state_d = frame_now ? ST_BREAK_WAIT : ST_IDLE;
          end
        end else if (samp_q == S_LAST) begin
          ferr_d = ferr_q | ~vote_q;
          bit_d  = bit_q + 1'b1;
        end
        ST_BREAK_WAIT: if (rxd_s) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (valid_q && rx_ready) valid_d = 1'b0;
    if (commit) begin
      if (!valid_q || rx_ready) begin
        valid_d    = 1'b1;
        data_d     = sh_q;
        perr_out_d = perr_q;
        ferr_out_d = frame_now;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    commit = tick && (state_q == ST_STOP) && (bit_q == B_STOP_LAST) && (samp_q == S_HI);
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = ovr_q;
endmodule
